uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter: grants one requester at a
// time, forwards its bytes one by one, and releases on end of message, burst limit or idle timeout.
module uart_tx_arbiter #(
    parameter int MAX_BURST     = 16,
    parameter int GRANT_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic       req0_last,
    input  logic       req1_last,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       grant_active,
    output logic       grant_id,
    output logic [1:0] dbg_state_o
);

    // Handshakes: a byte moves on a rising edge where valid && ready are both 1;
    // valid and its payload are held by the source until that edge, ready may toggle freely.

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(GRANT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_SEND    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               grant_id_q, grant_id_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               last_flag_q, last_flag_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               drain_first_q, drain_first_d;

    logic       gnt_valid;
    logic [7:0] gnt_data;
    logic       gnt_last;
    logic       release_grant;
    logic       rdy0, rdy1;

    assign gnt_valid = grant_id_q ? req1_valid : req0_valid;
    assign gnt_data  = grant_id_q ? req1_data  : req0_data;
    assign gnt_last  = grant_id_q ? req1_last  : req0_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= 1'b0;
            rr_ptr_q      <= 1'b0;
            burst_cnt_q   <= '0;
            idle_cnt_q    <= '0;
            last_flag_q   <= 1'b0;
            tx_data_q     <= 8'h00;
            drain_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            last_flag_q   <= last_flag_d;
            tx_data_q     <= tx_data_d;
            drain_first_q <= drain_first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        last_flag_d   = last_flag_q;
        tx_data_d     = tx_data_q;
        drain_first_d = drain_first_q;
        release_grant = 1'b0;
        rdy0          = 1'b0;
        rdy1          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_id_d = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
                    idle_cnt_d = '0;
                    state_d    = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                rdy0 = (grant_id_q == 1'b0) && tx_ready;
                rdy1 = (grant_id_q == 1'b1) && tx_ready;
                // A pending byte always beats the timeout, so the timeout only fires on an idle cycle.
                if (gnt_valid && tx_ready) begin
                    tx_data_d   = gnt_data;
                    last_flag_d = gnt_last;
                    burst_cnt_d = BURST_W'(burst_cnt_q + 1'b1);
                    idle_cnt_d  = '0;
                    state_d     = ST_SEND;
                end else if (gnt_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    release_grant = 1'b1;
                end else begin
                    idle_cnt_d = IDLE_W'(idle_cnt_q + 1'b1);
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    drain_first_d = 1'b1;
                    state_d       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The first drain cycle still shows the transmitter's pre-accept ready.
                drain_first_d = 1'b0;
                if (!drain_first_q && tx_ready) begin
                    if (last_flag_q || (burst_cnt_q == BURST_MAX)) begin
                        release_grant = 1'b1;
                    end else begin
                        state_d = ST_GRANTED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (release_grant) begin
            rr_ptr_d    = ~grant_id_q;
            burst_cnt_d = '0;
            idle_cnt_d  = '0;
            state_d     = ST_IDLE;
        end
    end

    assign req0_ready   = rdy0;
    assign req1_ready   = rdy1;
    assign tx_data      = tx_data_q;
    assign tx_valid     = (state_q == ST_SEND);
    assign grant_active = (state_q != ST_IDLE);
    assign grant_id     = grant_id_q;
    assign dbg_state_o  = state_q;

    a_one_ready: assert property (@(posedge clk) disable iff (reset) !(req0_ready && req1_ready));
    a_burst_cap: assert property (@(posedge clk) disable iff (reset) burst_cnt_q <= BURST_MAX);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted scenarios plus a long random run, checked by a
// per-requester expected-byte scoreboard and a round-robin grant model.
module tb_uart_tx_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_last = 1'b0, r1_last = 1'b0;
    logic       tx_ready = 1'b1;
    logic       req0_ready, req1_ready, tx_valid, grant_active, grant_id;
    logic [7:0] tx_data;
    logic [1:0] dbg_state;

    uart_tx_arbiter #(.MAX_BURST(MAXB), .GRANT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_data(r0_data), .req1_data(r1_data),
        .req0_valid(r0_valid), .req1_valid(r1_valid),
        .req0_last(r0_last), .req1_last(r1_last),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant_active(grant_active), .grant_id(grant_id),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [8:0] src_q0[$], src_q1[$];
    logic [8:0] exp_q0[$], exp_q1[$];
    logic [7:0] seg_log[$];
    int n_checks = 0, n_pass = 0;
    int acc_cnt = 0;
    bit seg_chk_en = 1'b1;
    bit tx_rand = 1'b0;
    int tx_busy_fixed = 0, tx_busy_max = 0, gap_max = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_byte(input int n, input logic [7:0] d, input logic l);
        if (n == 0) begin src_q0.push_back({l, d}); exp_q0.push_back({l, d}); end
        else        begin src_q1.push_back({l, d}); exp_q1.push_back({l, d}); end
    endtask

    function automatic int src_size(input int n);
        return (n == 0) ? src_q0.size() : src_q1.size();
    endfunction

    task automatic drive(input int n, input logic v, input logic [7:0] d, input logic l);
        if (n == 0) begin r0_valid = v; r0_data = d; r0_last = l; end
        else        begin r1_valid = v; r1_data = d; r1_last = l; end
    endtask

    // Requester driver: keeps valid up while its queue has bytes, pops on handshake.
    task automatic run_req(input int n);
        logic [8:0] e;
        int g;
        forever begin
            @(posedge clk); #1;
            if (src_size(n) == 0) begin
                drive(n, 1'b0, 8'h00, 1'b0);
                continue;
            end
            e = (n == 0) ? src_q0[0] : src_q1[0];
            drive(n, 1'b1, e[7:0], e[8]);
            @(negedge clk);
            if (!reset && ((n == 0) ? req0_ready : req1_ready)) begin
                if (n == 0) void'(src_q0.pop_front()); else void'(src_q1.pop_front());
                if (e[8] && gap_max > 0) begin
                    g = $urandom_range(0, gap_max);
                    if (g > 0) begin
                        @(posedge clk); #1;
                        drive(n, 1'b0, 8'h00, 1'b0);
                        repeat (g - 1) @(posedge clk);
                    end
                end
            end
        end
    endtask

    // Transmitter model: goes busy for a number of cycles after each accepted byte.
    initial begin : tx_model
        int b;
        forever begin
            @(negedge clk);
            if (!reset && tx_valid && tx_ready) begin
                @(posedge clk); #1;
                b = tx_rand ? $urandom_range(0, tx_busy_max) : tx_busy_fixed;
                if (b > 0) begin
                    tx_ready = 1'b0;
                    repeat (b) @(posedge clk);
                    #1;
                    tx_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: byte scoreboard, hold check, grant model, ready isolation.
    initial begin : sb_mon
        logic [8:0] e;
        logic model_rr, prev_active, pend_valid, pend_gid, hold_chk, seg_gid, seg_last;
        logic [7:0] held;
        int seg_cnt;
        model_rr = 0; prev_active = 0; pend_valid = 0; pend_gid = 0;
        hold_chk = 0; seg_gid = 0; seg_last = 0; held = 0; seg_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_rr = 0; prev_active = 0; pend_valid = 0; hold_chk = 0; seg_cnt = 0;
            end else begin
                if (hold_chk) begin
                    check("tx_hold", tx_data, held);
                    hold_chk = 0;
                end
                if (pend_valid) begin
                    check("grant_act", grant_active, 1);
                    check("grant_sel", grant_id, pend_gid);
                    pend_valid = 0;
                end
                if (!prev_active && grant_active) begin
                    seg_gid = grant_id; seg_cnt = 0; seg_last = 0;
                end
                if (prev_active && !grant_active) begin
                    seg_log.push_back({seg_gid, 7'(seg_cnt)});
                    if (seg_chk_en) check("release_cause", seg_last || (seg_cnt == MAXB), 1);
                    model_rr = ~seg_gid;
                end
                if (!grant_active) begin
                    check("idle_rdy", {req1_ready, req0_ready}, 0);
                    check("idle_txv", tx_valid, 0);
                    if (r0_valid || r1_valid) begin
                        pend_valid = 1;
                        pend_gid = (r0_valid && r1_valid) ? model_rr : r1_valid;
                    end
                end else begin
                    check("other_rdy", seg_gid ? req0_ready : req1_ready, 0);
                end
                if (tx_valid && tx_ready) begin
                    acc_cnt++;
                    e = 9'h0;
                    if (seg_gid) begin
                        if (exp_q1.size() == 0) check("sb_empty1", 1, 0); else e = exp_q1.pop_front();
                    end else begin
                        if (exp_q0.size() == 0) check("sb_empty0", 1, 0); else e = exp_q0.pop_front();
                    end
                    check("tx_data", tx_data, e[7:0]);
                    seg_cnt++;
                    seg_last = e[8];
                    check("burst_len", seg_cnt <= MAXB, 1);
                    held = e[7:0];
                    hold_chk = 1;
                end
                prev_active = grant_active;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        seg_log.delete();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (k < budget && !(src_q0.size() == 0 && src_q1.size() == 0 && exp_q0.size() == 0 &&
                               exp_q1.size() == 0 && !grant_active)) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < budget, 1);
    endtask

    task automatic check_seg(input string tag, input int i, input logic [7:0] exp);
        logic [7:0] got;
        got = (i < seg_log.size()) ? seg_log[i] : 8'hFF;
        check(tag, got, exp);
    endtask

    initial begin : main
        int k, len, tot_exp;
        logic [7:0] exp_c[5];
        fork
            run_req(0);
            run_req(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 8'h00);
        check("rst_rdy", {req1_ready, req0_ready}, 0);
        check("rst_ga", grant_active, 0);
        check("rst_gid", grant_id, 0);

        // single message with a slow transmitter
        tx_busy_fixed = 1086;
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'h5A, 1'b1);
        wait_idle(5000, "A_done");
        check("A_nseg", seg_log.size(), 1);
        check_seg("A_seg0", 0, {1'b0, 7'd2});
        seg_log.delete();
        tx_busy_fixed = 0;
        push_byte(0, 8'h11, 1'b1);
        push_byte(1, 8'h22, 1'b1);
        wait_idle(200, "A_rr_done");
        check_seg("A_rr0", 0, {1'b1, 7'd1});
        check_seg("A_rr1", 1, {1'b0, 7'd1});

        // contention after reset
        do_reset();
        tx_rand = 1'b1; tx_busy_max = 2;
        for (int i = 0; i < 3; i++) push_byte(0, 8'hB0 + 8'(i), i == 2);
        for (int i = 0; i < 3; i++) push_byte(1, 8'hC0 + 8'(i), i == 2);
        wait_idle(500, "B_done1");
        for (int i = 0; i < 2; i++) push_byte(0, 8'hD0 + 8'(i), i == 1);
        for (int i = 0; i < 2; i++) push_byte(1, 8'hE0 + 8'(i), i == 1);
        wait_idle(500, "B_done2");
        check("B_nseg", seg_log.size(), 4);
        check_seg("B_seg0", 0, {1'b0, 7'd3});
        check_seg("B_seg1", 1, {1'b1, 7'd3});
        check_seg("B_seg2", 2, {1'b0, 7'd2});
        check_seg("B_seg3", 3, {1'b1, 7'd2});

        // burst limit, tail of req0 released by timeout
        do_reset();
        seg_chk_en = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(0, 8'h40 + 8'(i), 1'b0);
        push_byte(1, 8'h90, 1'b0); push_byte(1, 8'h91, 1'b1);
        push_byte(1, 8'h92, 1'b0); push_byte(1, 8'h93, 1'b1);
        wait_idle(1000, "C_done");
        exp_c = '{8'h04, 8'h82, 8'h04, 8'h82, 8'h02};
        check("C_nseg", seg_log.size(), 5);
        for (int i = 0; i < 5; i++) check_seg("C_seg", i, exp_c[i]);

        // idle timeout
        do_reset();
        tx_rand = 1'b0; tx_busy_fixed = 0;
        push_byte(0, 8'h3C, 1'b0);
        k = 0;
        while (k < 100 && !(exp_q0.size() == 0 && dbg_state == ST_GRANTED)) begin
            @(negedge clk);
            k++;
        end
        check("D_reach_granted", k < 100, 1);
        push_byte(1, 8'hC3, 1'b1);
        k = 0;
        while (k < 64 && dbg_state == ST_GRANTED) begin
            k++;
            @(negedge clk);
        end
        check("D_timeout_len", k, TMO);
        check("D_released", grant_active, 0);
        @(negedge clk);
        check("D_regrant_ga", grant_active, 1);
        check("D_regrant_id", grant_id, 1);
        wait_idle(200, "D_done");
        check_seg("D_seg0", 0, {1'b0, 7'd1});
        check_seg("D_seg1", 1, {1'b1, 7'd1});
        seg_chk_en = 1'b1;

        // reset in the middle of DRAIN
        do_reset();
        tx_busy_fixed = 20;
        push_byte(0, 8'h77, 1'b0);
        push_byte(1, 8'h88, 1'b1);
        k = 0;
        while (k < 100 && dbg_state != ST_DRAIN) begin
            @(negedge clk);
            k++;
        end
        check("E_reach_drain", k < 100, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("E_state", dbg_state, ST_IDLE);
        check("E_txv", tx_valid, 0);
        check("E_rdy", {req1_ready, req0_ready}, 0);
        check("E_ga", grant_active, 0);
        seg_log.delete();
        @(negedge clk);
        check("E_grant_ga", grant_active, 1);
        check("E_grant_id", grant_id, 1);
        wait_idle(300, "E_done");
        check("E_nseg", seg_log.size(), 1);
        check_seg("E_seg0", 0, {1'b1, 7'd1});

        // random interleaving
        do_reset();
        tx_rand = 1'b1; tx_busy_max = 2; gap_max = 3;
        acc_cnt = 0; tot_exp = 0;
        for (int n = 0; n < 2; n++) begin
            k = 0;
            while (k < 1000) begin
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) push_byte(n, 8'($urandom_range(0, 255)), j == len - 1);
                k += len;
            end
            tot_exp += k;
        end
        wait_idle(60000, "R_done");
        check("R_bytes", acc_cnt, tot_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
